datapath_sequencer: RTL and testbench

Multi-cycle control sequencer for the Core101 datapath: owns the PC and instruction register and steps each instruction through fetch, decode, execute, optional memory access and writeback. Drives valid/ready handshakes toward instruction and data memory and one-cycle phase strobes toward the register file, ALU and decoder. Parametrised in data width and reset vector; it adds stall-tolerant handshakes, branch redirect and a sticky trap state.

---
 rtl/datapath_pkg.sv | 31 +++
 rtl/datapath_sequencer_pc_register.sv | 41 ++++
 rtl/datapath_sequencer.sv | 156 +++++++++++++++
 tb/tb_datapath_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the Core101 datapath sequencer: state encodings,
// trap cause codes, default address width and instruction length.
package datapath_pkg;

    localparam int DEFAULT_XLEN = 32;
    localparam int INSTR_BYTES  = 4;

    typedef enum logic [3:0] {
        ST_RESET      = 4'd0,
        ST_FETCH_REQ  = 4'd1,
        ST_FETCH_WAIT = 4'd2,
        ST_DECODE     = 4'd3,
        ST_EXECUTE    = 4'd4,
        ST_MEM_REQ    = 4'd5,
        ST_MEM_WAIT   = 4'd6,
        ST_WRITEBACK  = 4'd7,
        ST_TRAP       = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'd0,
        CAUSE_ILLEGAL    = 2'd1,
        CAUSE_MISALIGNED = 2'd2
    } cause_e;

    // Instruction addresses must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return addr_lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/datapath_sequencer_pc_register.sv
// Program counter: holds the current PC, computes the candidate next PC
// (sequential or branch target, wrapping modulo 2^XLEN) and flags a
// misaligned candidate so the sequencer can trap instead of loading it.
module pc_register
    import datapath_pkg::*;
#(
    parameter int               XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_en_i,
    input  logic            branch_sel_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic [XLEN-1:0] pc_o,
    output logic            misaligned_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] next_pc;

    // Next-PC mux; the sequential increment wraps silently at the top of the space.
    always_comb begin
        next_pc = branch_sel_i ? branch_target_i : (pc_q + XLEN'(INSTR_BYTES));
        pc_d    = load_en_i ? next_pc : pc_q;
    end

    // PC register, restarts at the reset vector.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o         = pc_q;
    assign misaligned_o = is_misaligned(next_pc[1:0]);

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer for the Core101 datapath. Steps each
// instruction through fetch, decode, execute, optional memory access and
// writeback with stall-tolerant handshakes; traps are sticky until reset.
// Every output is a register or a pure decode of the state register.
module datapath_sequencer
    import datapath_pkg::*;
#(
    parameter int               XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
    input  logic            datapath_clock,
    input  logic            datapath_reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            decode_is_mem,
    input  logic            decode_illegal,
    input  logic            exec_done,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    input  logic            dmem_resp_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [31:0]     ir_out,
    output logic            decode_en,
    output logic            execute_en,
    output logic            writeback_en,
    output logic            trap_valid,
    output logic [1:0]      trap_cause,
    output logic [3:0]      state_out
);

    state_e      state_q;
    state_e      state_d;
    logic [31:0] ir_q;
    logic [31:0] ir_d;
    cause_e      cause_q;
    cause_e      cause_d;

    logic            pc_load;
    logic            next_misaligned;
    logic [XLEN-1:0] pc;

    // PC only advances from writeback, and only to an aligned address.
    assign pc_load = (state_q == ST_WRITEBACK) && !next_misaligned;

    pc_register #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc (
        .clk_i           (datapath_clock),
        .rst_ni          (datapath_reset_n),
        .load_en_i       (pc_load),
        .branch_sel_i    (branch_taken),
        .branch_target_i (branch_target),
        .pc_o            (pc),
        .misaligned_o    (next_misaligned)
    );

    // State, instruction and trap-cause registers.
    always_ff @(posedge datapath_clock or negedge datapath_reset_n) begin
        if (!datapath_reset_n) begin
            state_q <= ST_RESET;
            ir_q    <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cause_q <= cause_d;
        end
    end

    // Next-state logic and state-decoded strobes/requests.
    always_comb begin
        state_d        = state_q;
        ir_d           = ir_q;
        cause_d        = cause_q;
        imem_req_valid = 1'b0;
        dmem_req_valid = 1'b0;
        decode_en      = 1'b0;
        execute_en     = 1'b0;
        writeback_en   = 1'b0;
        trap_valid     = 1'b0;

        case (state_q)
            ST_RESET: begin
                state_d = ST_FETCH_REQ;
            end
            ST_FETCH_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    state_d = ST_FETCH_WAIT;
                end
            end
            ST_FETCH_WAIT: begin
                if (imem_resp_valid) begin
                    ir_d    = imem_resp_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                decode_en = 1'b1;
                if (decode_illegal) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                execute_en = 1'b1;
                if (exec_done) begin
                    state_d = decode_is_mem ? ST_MEM_REQ : ST_WRITEBACK;
                end
            end
            ST_MEM_REQ: begin
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_resp_valid) begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                writeback_en = 1'b1;
                if (next_misaligned) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_MISALIGNED;
                end else begin
                    state_d = ST_FETCH_REQ;
                end
            end
            ST_TRAP: begin
                trap_valid = 1'b1;
            end
            default: begin
                // Corrupted state encoding: park in TRAP without a cause.
                state_d = ST_TRAP;
                cause_d = CAUSE_NONE;
            end
        endcase
    end

    assign imem_addr  = pc;
    assign pc_out     = pc;
    assign ir_out     = ir_q;
    assign trap_cause = cause_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: stimulus pushes the expected
// fetch/writeback/trap events, a monitor pops and compares them as the
// DUT produces them. A second 8-bit instance covers PC wrap-around.
module tb_datapath_sequencer;
    import datapath_pkg::*;

    localparam int          EV_FETCH = 0;
    localparam int          EV_WB    = 1;
    localparam int          EV_TRAP  = 2;
    localparam logic [31:0] RV       = 32'h0000_0100;
    localparam logic [31:0] INSN     = 32'hA5A5_0013;

    typedef struct {
        int          kind;
        logic [31:0] val;
        logic [1:0]  cause;
        int          gap;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_fetch = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [31:0] imem_addr, imem_resp_data;
    logic        decode_is_mem, decode_illegal, exec_done, branch_taken;
    logic [31:0] branch_target;
    logic        dmem_req_valid, dmem_req_ready, dmem_resp_valid;
    logic [31:0] pc_out, ir_out;
    logic        decode_en, execute_en, writeback_en, trap_valid;
    logic [1:0]  trap_cause;
    logic [3:0]  state_out;

    logic        d8_imem_req_valid, d8_dmem_req_valid;
    logic [7:0]  d8_imem_addr, d8_pc_out;
    logic [31:0] d8_ir_out;
    logic        d8_decode_en, d8_execute_en, d8_writeback_en, d8_trap_valid;
    logic [1:0]  d8_trap_cause;
    logic [3:0]  d8_state_out;
    logic        d8_one;
    logic        d8_zero;
    logic [7:0]  d8_target;

    datapath_sequencer #(.XLEN(32), .RESET_VECTOR(RV)) dut (
        .datapath_clock   (clk),
        .datapath_reset_n (rst_n),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_addr        (imem_addr),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .decode_is_mem    (decode_is_mem),
        .decode_illegal   (decode_illegal),
        .exec_done        (exec_done),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_ready   (dmem_req_ready),
        .dmem_resp_valid  (dmem_resp_valid),
        .pc_out           (pc_out),
        .ir_out           (ir_out),
        .decode_en        (decode_en),
        .execute_en       (execute_en),
        .writeback_en     (writeback_en),
        .trap_valid       (trap_valid),
        .trap_cause       (trap_cause),
        .state_out        (state_out)
    );

    datapath_sequencer #(.XLEN(8), .RESET_VECTOR(8'hFC)) dut8 (
        .datapath_clock   (clk),
        .datapath_reset_n (rst_n),
        .imem_req_valid   (d8_imem_req_valid),
        .imem_req_ready   (d8_one),
        .imem_addr        (d8_imem_addr),
        .imem_resp_valid  (d8_one),
        .imem_resp_data   (INSN),
        .decode_is_mem    (d8_zero),
        .decode_illegal   (d8_zero),
        .exec_done        (d8_one),
        .branch_taken     (d8_zero),
        .branch_target    (d8_target),
        .dmem_req_valid   (d8_dmem_req_valid),
        .dmem_req_ready   (d8_one),
        .dmem_resp_valid  (d8_one),
        .pc_out           (d8_pc_out),
        .ir_out           (d8_ir_out),
        .decode_en        (d8_decode_en),
        .execute_en       (d8_execute_en),
        .writeback_en     (d8_writeback_en),
        .trap_valid       (d8_trap_valid),
        .trap_cause       (d8_trap_cause),
        .state_out        (d8_state_out)
    );

    task automatic push(input int kind, input logic [31:0] val, input logic [1:0] cause,
                        input int gap);
        exp_t e;
        e.kind  = kind;
        e.val   = val;
        e.cause = cause;
        e.gap   = gap;
        sb_q.push_back(e);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_state(input state_e s, input string nm);
        int n;
        n = 0;
        while (state_out !== s && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (state_out !== s) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: state %0d, expected %0d", nm, state_out, s);
        end
    endtask

    task automatic observe(input int kind, input logic [31:0] val, input logic [1:0] cause);
        exp_t e;
        int   gap;
        tests++;
        gap = cyc - last_fetch;
        if (kind == EV_FETCH) last_fetch = cyc;
        if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind=%0d val=%0h, expected none", kind, val);
            return;
        end
        e = sb_q.pop_front();
        if (e.kind != kind || e.val !== val || e.cause !== cause ||
            (kind == EV_FETCH && e.gap >= 0 && gap != e.gap)) begin
            fails++;
            $display("FAIL event: got kind=%0d val=%0h cause=%0d gap=%0d, expected kind=%0d val=%0h cause=%0d gap=%0d",
                     kind, val, cause, gap, e.kind, e.val, e.cause, e.gap);
        end
    endtask

    // Monitor: samples between edges, after the stimulus has settled.
    initial begin
        logic trap_prev;
        trap_prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (!rst_n) begin
                trap_prev = 1'b0;
            end else begin
                if (imem_req_valid && imem_req_ready) observe(EV_FETCH, imem_addr, 2'd0);
                if (writeback_en) observe(EV_WB, pc_out, 2'd0);
                if (trap_valid && !trap_prev) observe(EV_TRAP, pc_out, trap_cause);
                trap_prev = trap_valid;
            end
        end
    end

    // Directed stimulus.
    initial begin
        rst_n           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = INSN;
        decode_is_mem   = 1'b0;
        decode_illegal  = 1'b0;
        exec_done       = 1'b0;
        branch_taken    = 1'b0;
        branch_target   = 32'h0;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        d8_one          = 1'b1;
        d8_zero         = 1'b0;
        d8_target       = 8'h00;
        repeat (2) @(negedge clk);

        check("reset_pc", pc_out, RV);
        check("reset_ir", ir_out, 32'h0);
        check("reset_state", {28'h0, state_out}, 32'h0);
        check("reset_strobes", {26'h0, imem_req_valid, dmem_req_valid, decode_en,
                                execute_en, writeback_en, trap_valid}, 32'h0);
        check("reset_cause", {30'h0, trap_cause}, 32'h0);

        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b1;
        exec_done       = 1'b1;
        dmem_req_ready  = 1'b1;
        dmem_resp_valid = 1'b1;
        push(EV_FETCH, 32'h100, 2'd0, -1);
        push(EV_WB,    32'h100, 2'd0, 0);
        push(EV_FETCH, 32'h104, 2'd0, 5);
        push(EV_WB,    32'h104, 2'd0, 0);
        push(EV_FETCH, 32'h108, 2'd0, 5);
        push(EV_WB,    32'h108, 2'd0, 0);
        push(EV_FETCH, 32'h10C, 2'd0, 12);
        push(EV_WB,    32'h10C, 2'd0, 0);
        push(EV_FETCH, 32'h200, 2'd0, 5);
        push(EV_WB,    32'h200, 2'd0, 0);
        push(EV_TRAP,  32'h200, 2'd2, 0);
        rst_n = 1'b1;

        // Two plain instructions; the 8-bit instance wraps FC -> 00 alongside.
        wait_state(ST_WRITEBACK, "wb_100");
        check("w8_pc_before", {24'h0, d8_pc_out}, 32'hFC);
        @(negedge clk);
        check("w8_wrap_addr", {24'h0, d8_imem_addr}, 32'h00);
        check("w8_fetch_valid", {31'h0, d8_imem_req_valid}, 32'h1);
        wait_state(ST_WRITEBACK, "wb_104");
        @(negedge clk);

        // Memory instruction with the data response held off two cycles.
        decode_is_mem   = 1'b1;
        dmem_resp_valid = 1'b0;
        wait_state(ST_MEM_WAIT, "mem_wait");
        repeat (2) @(negedge clk);
        dmem_resp_valid = 1'b1;
        wait_state(ST_WRITEBACK, "wb_108");
        decode_is_mem  = 1'b0;
        imem_req_ready = 1'b0;

        // Fetch stalled three cycles: request and address must stay put.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_valid", {31'h0, imem_req_valid}, 32'h1);
            check("stall_addr", imem_addr, 32'h10C);
            if (i == 3) imem_req_ready = 1'b1;
        end
        @(negedge clk);
        check("stall_to_fetch_wait", {28'h0, state_out}, 32'h2);

        // Taken branch to an aligned target, then to a misaligned one.
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        wait_state(ST_WRITEBACK, "wb_10c");
        @(negedge clk);
        branch_target = 32'h202;
        wait_state(ST_TRAP, "trap_misaligned");
        check("mis_cause", {30'h0, trap_cause}, 32'h2);
        check("mis_pc", pc_out, 32'h200);
        check("mis_ir", ir_out, INSN);
        repeat (5) @(negedge clk);
        check("trap_quiet", {26'h0, imem_req_valid, dmem_req_valid, decode_en,
                             execute_en, writeback_en, trap_valid}, 32'h1);
        check("trap_sticky", {28'h0, state_out}, 32'h8);

        // Reset in the middle of TRAP.
        rst_n = 1'b0;
        #1;
        check("rst_trap_pc", pc_out, RV);
        check("rst_trap_valid", {31'h0, trap_valid}, 32'h0);
        check("rst_trap_cause", {30'h0, trap_cause}, 32'h0);
        check("rst_trap_ir", ir_out, 32'h0);
        branch_taken   = 1'b0;
        decode_illegal = 1'b1;
        push(EV_FETCH, 32'h100, 2'd0, -1);
        push(EV_TRAP,  32'h100, 2'd1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Illegal instruction traps straight out of DECODE.
        wait_state(ST_TRAP, "trap_illegal");
        check("ill_cause", {30'h0, trap_cause}, 32'h1);
        check("ill_pc", pc_out, RV);
        repeat (3) @(negedge clk);
        #3;
        check("scoreboard_drained", sb_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
